seg_display_mux: RTL and testbench

SEG_DISPLAY_MUX -- requirements
Module: seg_display_mux

---
 rtl/seg_display_mux.sv | 131 +++++++++++++
 tb/tb_seg_display_mux.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_mux.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// seg_display_mux : two-digit multiplexed 7-segment driver fed by an
//                   AXI-Stream frame, with optional post-accept hold-off.
// Revision        : 1.0
// =============================================================================
module seg_display_mux #(
  parameter int         REFRESH     = 50000,
  parameter int         HOLD        = 0,
  parameter bit         SEG_ACT_LOW = 1'b1,
  parameter bit         BLANK_LEAD  = 1'b1,
  parameter logic [6:0] ZERO_CODE   = 7'b1111110
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [1:0][6:0] s_data,
  output logic [6:0]      seg,
  output logic [1:0]      an,
  output logic            frame_vld
);

  localparam int c_cnt_w       = (REFRESH > 1) ? $clog2(REFRESH) : 1;
  localparam int c_hold_w      = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
  localparam int c_hold_init_i = (HOLD > 0) ? HOLD - 1 : 0;

  localparam logic [c_cnt_w-1:0]  c_cnt_max   = c_cnt_w'(REFRESH - 1);
  localparam logic [c_hold_w-1:0] c_hold_init = c_hold_w'(c_hold_init_i);
  localparam logic [6:0]          c_seg_off   = SEG_ACT_LOW ? 7'h7F : 7'h00;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHOW    = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_hold_w-1:0]  r_hold_cnt;
  logic [c_cnt_w-1:0]   r_refresh_cnt;
  logic                 r_digit_sel;
  logic [1:0][6:0]      r_disp;

  logic                 w_xfer;
  logic [6:0]           w_code;
  logic                 w_blank;
  logic [1:0]           w_an_nxt;
  logic [6:0]           w_seg_nxt;

  assign w_xfer = s_valid && s_ready;

  // Control FSM; s_ready is registered from the state being entered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= '0;
      r_disp     <= '0;
      s_ready    <= 1'b0;
      frame_vld  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_SHOW: begin
          s_ready <= 1'b1;
          if (w_xfer) begin
            r_disp    <= s_data;
            frame_vld <= 1'b1;
            if (HOLD == 0) begin
              r_state <= ST_SHOW;
            end else begin
              r_state    <= ST_HOLDOFF;
              r_hold_cnt <= c_hold_init;
              s_ready    <= 1'b0;
            end
          end
        end
        ST_HOLDOFF: begin
          if (r_hold_cnt == '0) begin
            r_state <= ST_SHOW;
            s_ready <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          s_ready <= 1'b1;
        end
      endcase
    end
  end

  // Free-running slot timer, independent of frame traffic.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_refresh_cnt <= '0;
      r_digit_sel   <= 1'b0;
    end else if (r_refresh_cnt == c_cnt_max) begin
      r_refresh_cnt <= '0;
      r_digit_sel   <= ~r_digit_sel;
    end else begin
      r_refresh_cnt <= r_refresh_cnt + 1'b1;
    end
  end

  always_comb begin
    w_code    = r_digit_sel ? r_disp[1] : r_disp[0];
    w_blank   = (r_state == ST_IDLE) ||
                (BLANK_LEAD && r_digit_sel && (r_disp[1] == ZERO_CODE));
    w_an_nxt  = 2'b11;
    w_seg_nxt = c_seg_off;
    if (!w_blank) begin
      w_seg_nxt = SEG_ACT_LOW ? ~w_code : w_code;
      if (r_refresh_cnt != '0) begin
        w_an_nxt = r_digit_sel ? 2'b01 : 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      an  <= 2'b11;
      seg <= c_seg_off;
    end else begin
      an  <= w_an_nxt;
      seg <= w_seg_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_display_mux.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// tb_seg_display_mux : table-driven bench with expected-frame scoreboard.
// Revision           : 1.0
// =============================================================================
module tb_seg_display_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rstn;
  logic            va, vb, ra, rb, fva, fvb;
  logic [1:0][6:0] da, db;
  logic [6:0]      sega, segb;
  logic [1:0]      ana, anb;

  seg_display_mux #(.REFRESH(4), .HOLD(3), .SEG_ACT_LOW(1'b1), .BLANK_LEAD(1'b1),
                    .ZERO_CODE(7'b1111110)) u_dut_a (
    .clk(clk), .rstn(rstn), .s_valid(va), .s_ready(ra), .s_data(da),
    .seg(sega), .an(ana), .frame_vld(fva));

  seg_display_mux #(.REFRESH(4), .HOLD(0), .SEG_ACT_LOW(1'b1), .BLANK_LEAD(1'b1),
                    .ZERO_CODE(7'b1111110)) u_dut_b (
    .clk(clk), .rstn(rstn), .s_valid(vb), .s_ready(rb), .s_data(db),
    .seg(segb), .an(anb), .frame_vld(fvb));

  typedef struct {
    logic [6:0] ones;
    logic [6:0] tens;
    logic [6:0] ones_seg;
    logic [6:0] tens_seg;
    bit         tens_blank;
  } vec_t;

  typedef struct {
    logic [6:0] ones_seg;
    logic [6:0] tens_seg;
    bit         tens_blank;
  } exp_t;

  vec_t vecs [4];
  exp_t exp_q [$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;
  int xfer_a = 0;
  int xfer_b = 0;
  bit use_b = 1'b0;

  logic [1:0] an_m;
  logic [6:0] seg_m;
  logic       rdy_m;
  assign an_m  = use_b ? anb  : ana;
  assign seg_m = use_b ? segb : sega;
  assign rdy_m = use_b ? rb   : ra;

  // Cycles since reset release; locates the current refresh slot.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(posedge clk) begin
    if (rstn && va && ra) xfer_a <= xfer_a + 1;
    if (rstn && vb && rb) xfer_b <= xfer_b + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk_exp(input vec_t v);
    exp_t e;
    e.ones_seg   = v.ones_seg;
    e.tens_seg   = v.tens_seg;
    e.tens_blank = v.tens_blank;
    return e;
  endfunction

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (rdy_m !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (rdy_m !== 1'b1) check({tag, "_ready_wait"}, rdy_m, 1);
  endtask

  task automatic count_low(output int low);
    low = 0;
    while (rdy_m === 1'b0 && low < 50) begin
      low++;
      @(negedge clk);
    end
  endtask

  // Called at a negedge with s_ready high on DUT A; returns hold-off length.
  task automatic send_a(input vec_t v, output int low);
    wait_ready("send");
    da = {v.tens, v.ones};
    va = 1'b1;
    exp_q.push_back(mk_exp(v));
    @(negedge clk);
    va = 1'b0;
    count_low(low);
  endtask

  // Compares one full refresh period against the newest queued frame.
  task automatic observe(input string tag);
    exp_t       e;
    int         idx;
    logic [1:0] exp_an;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
      return;
    end
    while (exp_q.size() > 1) exp_q.delete(0);
    e = exp_q.pop_front();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      idx = (cyc - 1) % 8;
      if (idx % 4 == 0)  exp_an = 2'b11;
      else if (idx < 4)  exp_an = 2'b10;
      else               exp_an = e.tens_blank ? 2'b11 : 2'b01;
      check({tag, "_an"}, an_m, exp_an);
      if (exp_an == 2'b10)      check({tag, "_seg_ones"}, seg_m, e.ones_seg);
      else if (exp_an == 2'b01) check({tag, "_seg_tens"}, seg_m, e.tens_seg);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_seg"},   sega, 7'h7F);
    check({tag, "_an"},    ana,  2'b11);
    check({tag, "_ready"}, ra,   1'b0);
    check({tag, "_fvld"},  fva,  1'b0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rstn = 1'b1;
    check("rel_ready_before_edge", ra, 1'b0);
    @(negedge clk);
    check("rel_ready_after_edge", ra, 1'b1);
    check("rel_fvld", fva, 1'b0);
  endtask

  initial begin
    int low, x0, n;
    vecs[0] = '{7'b1011011, 7'b0110000, 7'b0100100, 7'b1001111, 1'b0};
    vecs[1] = '{7'b0110011, 7'b1111110, 7'b1001100, 7'b0000001, 1'b1};
    vecs[2] = '{7'b1111110, 7'b0110000, 7'b0000001, 7'b1001111, 1'b0};
    vecs[3] = '{7'b1111111, 7'b0000000, 7'b0000000, 7'b1111111, 1'b0};

    rstn = 1'b0; va = 1'b0; vb = 1'b0; da = '0; db = '0;
    #12;
    check_reset_outputs("reset");
    release_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("idle_an", ana, 2'b11);
      check("idle_seg", sega, 7'h7F);
    end

    // Table of frames on the HOLD=3 instance.
    foreach (vecs[i]) begin
      send_a(vecs[i], low);
      check("holdoff_len", low, 3);
      check("frame_vld", fva, 1'b1);
      observe("vec");
    end

    // Backpressure: second frame waits through hold-off with valid held high.
    wait_ready("bp");
    x0 = xfer_a;
    da = {vecs[0].tens, vecs[0].ones};
    va = 1'b1;
    @(negedge clk);
    da = {vecs[2].tens, vecs[2].ones};
    count_low(low);
    check("bp_holdoff1", low, 3);
    check("bp_xfers_during_hold", xfer_a - x0, 1);
    exp_q.push_back(mk_exp(vecs[2]));
    @(negedge clk);
    va = 1'b0;
    count_low(low);
    check("bp_holdoff2", low, 3);
    check("bp_xfers_total", xfer_a - x0, 2);
    observe("bp");

    // Asynchronous reset inside an enabled digit slot.
    n = 0;
    while (ana === 2'b11 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("mid_disp_slot_found", (ana !== 2'b11), 1'b1);
    #2 rstn = 1'b0;
    #1 check_reset_outputs("async_rst_disp");
    exp_q.delete();
    release_reset();

    // Asynchronous reset during hold-off discards the frame.
    wait_ready("mh");
    da = {vecs[0].tens, vecs[0].ones};
    va = 1'b1;
    @(negedge clk);
    va = 1'b0;
    check("mh_in_holdoff", ra, 1'b0);
    #2 rstn = 1'b0;
    #1 check_reset_outputs("async_rst_hold");
    release_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst_idle_an", ana, 2'b11);
    end

    // Back-to-back frames on the HOLD=0 instance.
    use_b = 1'b1;
    check("b_ready", rb, 1'b1);
    x0 = xfer_b;
    db = {vecs[0].tens, vecs[0].ones};
    vb = 1'b1;
    exp_q.push_back(mk_exp(vecs[0]));
    @(negedge clk);
    check("b_ready_2nd", rb, 1'b1);
    db = {vecs[3].tens, vecs[3].ones};
    exp_q.push_back(mk_exp(vecs[3]));
    @(negedge clk);
    vb = 1'b0;
    check("b_ready_after", rb, 1'b1);
    check("b_xfers", xfer_b - x0, 2);
    check("b_fvld", fvb, 1'b1);
    observe("b2b");
    check("b_ready_end", rb, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
